// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the move sequencer: opcodes, FSM state encoding and
// the desired-heading decode applied to an accepted command.
package move_sequencer_pkg;

    localparam logic [3:0] OP_CAL  = 4'h0;
    localparam logic [3:0] OP_MOVE = 4'h2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_ROTATE,
        S_RAMP_UP,
        S_RAMP_DOWN,
        S_DONE
    } state_t;

    // A zero heading code means "north" exactly; otherwise the code is the top byte
    function automatic logic [11:0] decode_heading(input logic [7:0] code);
        return (code != 8'h00) ? {code, 4'hF} : 12'h000;
    endfunction

endpackage

// File: rtl/move_sequencer_line_counter.sv
// Centre-line crossing counter: cntrIR synchroniser, rising-edge detect and a
// saturating 5-bit count with synchronous clear and count enable.
module line_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cntr_ir,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [4:0] o_count
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic [4:0] r_count;
    logic       w_rise;

    assign w_rise  = r_sync2 & ~r_prev;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_count <= 5'h00;
        end else begin
            r_sync1 <= i_cntr_ir;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (i_clr)
                r_count <= 5'h00;
            else if (i_en && w_rise && (r_count != 5'h1F))
                r_count <= r_count + 5'h01;
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Command-level sequencer for one calibration or move at a time, feeding the PID.
// Optional build macro LINE_CORR_EN adds guard-rail IR correction to the error.
module move_sequencer #(
    parameter logic [9:0]  FRWRD_MAX   = 10'h2A0,
    parameter logic [5:0]  FRWRD_INC   = 6'h04,
    parameter logic [11:0] ERR_THRESH  = 12'h02C,
    parameter logic [11:0] CORR_OFFSET = 12'h01E
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    input  logic        lftIR,
    input  logic        rghtIR,
    input  logic        cal_done,
    output logic        strt_cal,
    output logic        moving,
    output logic [9:0]  frwrd,
    output logic [11:0] error,
    output logic        err_vld
);
    import move_sequencer_pkg::*;

    state_t      r_state;
    logic [11:0] r_desired;
    logic [4:0]  r_target;
    logic        r_rot_only;
    logic [9:0]  r_frwrd;
    logic [11:0] r_error;
    logic        r_err_vld;
    logic        r_clr_cmd_rdy;
    logic        r_send_resp;
    logic        r_strt_cal;

    logic        w_accept;
    logic        w_moving;
    logic        w_ramping;
    logic [4:0]  w_line_cnt;
    logic        w_at_target;
    logic        w_going_down;
    logic [11:0] w_err_abs;
    logic        w_settled;
    logic [10:0] w_up_sum;
    logic [9:0]  w_frwrd_up;
    logic [9:0]  w_dn_step;
    logic [9:0]  w_frwrd_dn;
    logic [11:0] w_diff;
    logic [11:0] w_err_next;

    // r_clr_cmd_rdy masks the cycle where the front end has not yet dropped cmd_rdy
    assign w_accept     = (r_state == S_IDLE) && cmd_rdy && !r_clr_cmd_rdy;
    assign w_moving     = (r_state == S_ROTATE) || (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign w_ramping    = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign w_at_target  = (w_line_cnt == r_target);
    assign w_going_down = (r_state == S_RAMP_DOWN) || ((r_state == S_RAMP_UP) && w_at_target);

    assign w_err_abs  = r_error[11] ? (~r_error + 12'h001) : r_error;
    assign w_settled  = r_err_vld && (w_err_abs < ERR_THRESH);

    assign w_up_sum   = {1'b0, r_frwrd} + {5'b0, FRWRD_INC};
    assign w_frwrd_up = (w_up_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : w_up_sum[9:0];
    assign w_dn_step  = {3'b0, FRWRD_INC, 1'b0};
    assign w_frwrd_dn = (r_frwrd < w_dn_step) ? 10'h000 : (r_frwrd - w_dn_step);

    // Heading is circular, so the 12-bit wrap of the difference is the shortest error
    assign w_diff = heading - r_desired;

`ifdef LINE_CORR_EN
    logic        r_lft_s1, r_lft_s2, r_rght_s1, r_rght_s2;
    logic [12:0] w_corr;
    logic [12:0] w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_s1  <= 1'b0;
            r_lft_s2  <= 1'b0;
            r_rght_s1 <= 1'b0;
            r_rght_s2 <= 1'b0;
        end else begin
            r_lft_s1  <= lftIR;
            r_lft_s2  <= r_lft_s1;
            r_rght_s1 <= rghtIR;
            r_rght_s2 <= r_rght_s1;
        end
    end

    always_comb begin
        w_corr = 13'h0000;
        if (w_ramping && (r_lft_s2 ^ r_rght_s2))
            w_corr = r_lft_s2 ? {1'b0, CORR_OFFSET} : (~{1'b0, CORR_OFFSET} + 13'h0001);
    end

    assign w_sum      = {w_diff[11], w_diff} + w_corr;
    assign w_err_next = (w_sum[12] != w_sum[11]) ? (w_sum[12] ? 12'h800 : 12'h7FF) : w_sum[11:0];
`else
    logic w_unused_ir;
    assign w_unused_ir = lftIR ^ rghtIR;
    assign w_err_next  = w_diff;
`endif

    line_counter u_line_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cntr_ir (cntrIR),
        .i_clr     (w_accept),
        .i_en      (w_ramping),
        .o_count   (w_line_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_desired     <= 12'h000;
            r_target      <= 5'h00;
            r_rot_only    <= 1'b0;
            r_frwrd       <= 10'h000;
            r_error       <= 12'h000;
            r_err_vld     <= 1'b0;
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_strt_cal    <= 1'b0;
        end else begin
            r_clr_cmd_rdy <= 1'b0;
            r_send_resp   <= 1'b0;
            r_strt_cal    <= 1'b0;
            r_err_vld     <= heading_rdy && w_moving;
            if (heading_rdy && w_moving)
                r_error <= w_err_next;
            if (heading_rdy) begin
                if (w_going_down)
                    r_frwrd <= w_frwrd_dn;
                else if (r_state == S_RAMP_UP)
                    r_frwrd <= w_frwrd_up;
            end

            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_clr_cmd_rdy <= 1'b1;
                    r_desired     <= decode_heading(cmd[11:4]);
                    r_target      <= {cmd[3:0], 1'b0};
                    r_rot_only    <= (cmd[3:0] == 4'h0);
                    case (cmd[15:12])
                        OP_CAL: begin
                            r_strt_cal <= 1'b1;
                            r_state    <= S_CAL;
                        end
                        OP_MOVE: begin
                            r_frwrd <= 10'h000;
                            r_state <= S_ROTATE;
                        end
                        default: r_send_resp <= 1'b1;
                    endcase
                end
                S_CAL:       if (cal_done) r_state <= S_DONE;
                S_ROTATE:    if (w_settled) r_state <= r_rot_only ? S_DONE : S_RAMP_UP;
                S_RAMP_UP:   if (w_at_target) r_state <= S_RAMP_DOWN;
                S_RAMP_DOWN: if (r_frwrd == 10'h000) r_state <= S_DONE;
                S_DONE: begin
                    r_send_resp <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign clr_cmd_rdy = r_clr_cmd_rdy;
    assign send_resp   = r_send_resp;
    assign strt_cal    = r_strt_cal;
    assign moving      = w_moving;
    assign frwrd       = r_frwrd;
    assign error       = r_error;
    assign err_vld     = r_err_vld;

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Command-level controller that sequences the PID steering loop for one move at a time.
- Decodes a 16-bit command and starts calibration or a move.
- For a move: produces the heading error and its valid strobe; drives the moving flag and a ramped forward speed into the PID loop.
- Counts centre-line crossings to end the move. Sits between the command/UART front end and the PID.

Parameters:
- FRWRD_MAX, 10'h2A0, saturation ceiling for frwrd during ramp-up
- FRWRD_INC, 6'h04, ramp-up step applied per heading_rdy; ramp-down step is 2*FRWRD_INC
- ERR_THRESH, 12'h02C, magnitude below which rotation counts as settled
- CORR_OFFSET, 12'h01E, lateral IR correction magnitude (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  [15:12] opcode, [11:4] heading code, [3:0] squares
- cmd_rdy  in  1  command valid (level)
- clr_cmd_rdy  out  1  one-cycle pulse: command consumed
- send_resp  out  1  one-cycle pulse: command complete
- heading  in  12  signed current heading from gyro
- heading_rdy  in  1  one-cycle pulse: new heading sample
- cntrIR  in  1  centre IR line sensor
- lftIR  in  1  left guard-rail IR
- rghtIR  in  1  right guard-rail IR
- cal_done  in  1  gyro calibration finished pulse
- strt_cal  out  1  one-cycle pulse: start gyro calibration
- moving  out  1  enables PID integrator and wheel speeds
- frwrd  out  10  unsigned forward speed to PID
- error  out  12  signed heading error to PID (registered)
- err_vld  out  1  error valid pulse

Behaviour:
- Reset: state IDLE; all outputs 0; frwrd=0; line counter=0; error=0.
- Opcodes:
  - 4'h0: calibrate.
  - 4'h2: move.
  - Anything else: illegal. Pulse clr_cmd_rdy and send_resp on the same cycle; stay in IDLE.
- Heading decode, latched at accept:
  - desired_heading = {cmd[11:4],4'hF} when cmd[11:4]!=0, else 12'h000.
  - Line target = 2*cmd[3:0], 5 bits.
  - squares=0: rotate only; skip RAMP_UP and RAMP_DOWN and go ROTATE -> DONE.
- States: IDLE, CAL, ROTATE, RAMP_UP, RAMP_DOWN, DONE.
  - IDLE: when cmd_rdy=1, pulse clr_cmd_rdy for one cycle and accept the command. cmd_rdy is ignored in every other state.
  - IDLE -> CAL: pulse strt_cal for one cycle. Stay in CAL until cal_done, then go to DONE.
  - ROTATE: moving=1, frwrd=0. Leave on the first err_vld cycle with |error| < ERR_THRESH (strict).
  - RAMP_UP: on each heading_rdy, frwrd += FRWRD_INC, saturating at FRWRD_MAX. When the line count equals the target, go to RAMP_DOWN.
  - RAMP_DOWN: on each heading_rdy, frwrd -= 2*FRWRD_INC, clamped at 0. When frwrd==0 with moving still 1, go to DONE.
  - DONE: pulse send_resp for one cycle, clear moving, go to IDLE.
- moving=1 only in ROTATE, RAMP_UP and RAMP_DOWN.
- frwrd holds its value between heading_rdy pulses. It never changes outside RAMP_UP and RAMP_DOWN; it is zeroed on entry to ROTATE.
- error = heading - desired_heading, 12-bit two's complement wrap (heading is circular).
  - Registered on heading_rdy. err_vld = heading_rdy delayed one cycle (1-cycle latency).
  - error and err_vld keep updating in all moving states.
- Line counter:
  - cntrIR is double-flopped for synchronisation; the counter increments on each rising edge.
  - Cleared on command accept. Counts only in RAMP_UP and RAMP_DOWN.
  - Saturates at 5'h1F.
- A heading_rdy that coincides with the transition into RAMP_DOWN uses the ramp-down step.
- Async reset mid-move returns to IDLE immediately, with frwrd=0 and moving=0. No send_resp is issued.

Optional Feature:
- LINE_CORR_EN defined:
  - In RAMP_UP and RAMP_DOWN, synchronised lftIR=1 adds +CORR_OFFSET to the registered error.
  - rghtIR=1 adds -CORR_OFFSET. Both asserted: no correction.
  - The addition saturates at 12'h7FF and 12'h800.
- Undefined: lftIR and rghtIR are unused, and error is the pure heading difference.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_CAL=4'h0, OP_MOVE=4'h2);
  - the state enum typedef;
  - the desired-heading decode function.
- One sub-module: line_counter, containing the cntrIR synchroniser, rising-edge detect and saturating 5-bit counter with clear and enable.

Test Plan:
- cmd=16'h0000 with cmd_rdy -> clr_cmd_rdy pulse and strt_cal pulse; cal_done 10 cycles later -> send_resp on the following cycle; moving stays 0.
- cmd=16'h2001, heading=12'h000 -> desired heading 000, ROTATE exits on the first err_vld. Drive 10 heading_rdy pulses -> frwrd reaches 10'h028.
- In the same move, 2 cntrIR rising edges -> RAMP_DOWN; frwrd drops by 8 per heading_rdy; at frwrd=0 -> send_resp and moving falls.
- cmd=16'h23F0 (squares=0), heading=12'h100 -> error = 12'h100 - 12'h3FF = 12'hD01. Step heading until |error| < 12'h02C -> send_resp with frwrd=0 throughout.
- 200 heading_rdy pulses in RAMP_UP -> frwrd saturates exactly at 10'h2A0. Assert rst_n low mid-ramp -> frwrd=0, moving=0 asynchronously, no send_resp.
- With LINE_CORR_EN, heading=desired and lftIR=1 during RAMP_UP -> error=12'h01E; with both IR asserted -> error=12'h000.
